// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan chain sequencer.
//   seq_state_t  : sequencer state encoding
//   MODE_*       : bit positions inside the 3-bit command mode
//   ceil_div     : integer ceiling division (bytes needed for a chain)
//   first_phase  : first enabled phase for a mode, in LOAD, RUN, DUMP order
package scan_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DUMP = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    localparam int MODE_LOAD = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_DUMP = 2;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Callers clear the bits of phases already done, so the same helper
    // picks the phase after LOAD or after RUN as well.
    function automatic seq_state_t first_phase(input logic [2:0] m);
        if (m[MODE_LOAD]) return LOAD;
        else if (m[MODE_RUN]) return RUN;
        else if (m[MODE_DUMP]) return DUMP;
        else return DONE;
    endfunction

endpackage

// File: rtl/scan_byte_shifter.sv
// 8-bit parallel/serial byte buffer with a bit counter.
//   i_clear               : empty the buffer (data and count to 0)
//   i_load/i_load_data/
//   i_load_cnt            : parallel load with the number of valid bits
//   i_shift_out           : drop bit 0 (serialiser), count - 1
//   i_shift_in/i_bit      : place i_bit at position count (deserialiser), count + 1
//   o_data                : buffer contents
//   o_bit                 : current serial output bit (bit 0)
//   o_empty / o_full      : count == 0 / count == 8
// Priority: clear > load > shift_out > shift_in.
module scan_byte_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic [3:0] i_load_cnt,
    input  logic       i_shift_out,
    input  logic       i_shift_in,
    input  logic       i_bit,
    output logic [7:0] o_data,
    output logic       o_bit,
    output logic       o_empty,
    output logic       o_full
);

    logic [7:0] r_buf;
    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_buf <= i_load_data;
            r_cnt <= i_load_cnt;
        end else if (i_shift_out) begin
            r_buf <= {1'b0, r_buf[7:1]};
            r_cnt <= r_cnt - 4'd1;
        end else if (i_shift_in) begin
            r_buf[r_cnt[2:0]] <= i_bit;
            r_cnt             <= r_cnt + 4'd1;
        end
    end

    assign o_data  = r_buf;
    assign o_bit   = r_buf[0];
    assign o_empty = (r_cnt == 4'd0);
    assign o_full  = (r_cnt == 4'd8);

endmodule

// File: rtl/scan_chain_sequencer.sv
// Host-side sequencer that loads, runs and dumps the accumulator core
// through its scan chain and proc_en/halt pins.
//   clk, rst (async, active low)
//   start/mode        : command strobe, mode [0] load [1] run [2] dump
//   busy/done         : command in progress / one-cycle completion pulse
//   timed_out         : last run ended by the watchdog
//   in_data/in_valid/in_ready    : load byte stream, chain bits LSB first
//   out_data/out_valid/out_ready : dump byte stream, chain bits LSB first
//   core_*            : scan and run control towards the core
// Build option: define RUN_TIMEOUT_EN to add the run watchdog
// (MAX_RUN_CYCLES, counter width TMR_W); otherwise timed_out is tied 0.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | take host bytes, shift CHAIN_LEN bits into the chain
// RUN   | proc_en high until halt (or watchdog)
// DUMP  | recirculate CHAIN_LEN bits, stream them to the host
// DONE  | one-cycle done pulse
module scan_chain_sequencer
    import scan_seq_pkg::*;
#(
    parameter int CHAIN_LEN      = 280,
    parameter int MAX_RUN_CYCLES = 65535,
    parameter int TMR_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] mode,
    output logic       busy,
    output logic       done,
    output logic       timed_out,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       core_scan_enable,
    output logic       core_scan_in,
    input  logic       core_scan_out,
    output logic       core_proc_en,
    input  logic       core_halt
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);

    seq_state_t      r_state, w_next_state;
    logic [2:0]      r_mode;
    logic [BL_W-1:0] r_bits_left;

    logic       w_ld_bit, w_ld_empty, w_ld_unused_full;
    logic [7:0] w_ld_unused_data;
    logic [7:0] w_dm_data;
    logic       w_dm_empty, w_dm_full, w_dm_unused_bit;

    wire w_start_acc = (r_state == IDLE) && start;
    wire w_bits_zero = (r_bits_left == '0);
    wire w_entering  = (w_next_state != r_state) &&
                       ((w_next_state == LOAD) || (w_next_state == DUMP));

    wire w_ld_take  = (r_state == LOAD) && w_ld_empty && !w_bits_zero && in_valid;
    wire w_ld_shift = (r_state == LOAD) && !w_ld_empty;
    // Final load byte only carries the remaining bits; the rest are dropped.
    wire [3:0] w_ld_cnt = (r_bits_left > BL_W'(7)) ? 4'd8 : 4'(r_bits_left);

    // A dump byte is ready when full, or when the chain is exhausted mid-byte.
    wire w_dm_ready = w_dm_full || (w_bits_zero && !w_dm_empty);
    wire w_dm_shift = (r_state == DUMP) && !w_dm_ready && !w_bits_zero;
    wire w_dm_take  = (r_state == DUMP) && w_dm_ready && out_ready;

    scan_byte_shifter u_load_buf (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (1'b0),
        .i_load      (w_ld_take),
        .i_load_data (in_data),
        .i_load_cnt  (w_ld_cnt),
        .i_shift_out (w_ld_shift),
        .i_shift_in  (1'b0),
        .i_bit       (1'b0),
        .o_data      (w_ld_unused_data),
        .o_bit       (w_ld_bit),
        .o_empty     (w_ld_empty),
        .o_full      (w_ld_unused_full)
    );

    scan_byte_shifter u_dump_buf (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_dm_take || (w_entering && (w_next_state == DUMP))),
        .i_load      (1'b0),
        .i_load_data (8'h00),
        .i_load_cnt  (4'd0),
        .i_shift_out (1'b0),
        .i_shift_in  (w_dm_shift),
        .i_bit       (core_scan_out),
        .o_data      (w_dm_data),
        .o_bit       (w_dm_unused_bit),
        .o_empty     (w_dm_empty),
        .o_full      (w_dm_full)
    );

`ifdef RUN_TIMEOUT_EN
    logic [TMR_W-1:0] r_run_cnt;
    logic             r_timed_out;
    wire w_run_tmo = (r_state == RUN) && (r_run_cnt == TMR_W'(MAX_RUN_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt   <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_run_cnt <= (r_state == RUN) ? r_run_cnt + 1'b1 : '0;
            if (w_start_acc)
                r_timed_out <= 1'b0;
            else if (w_run_tmo && !core_halt)
                r_timed_out <= 1'b1;
        end
    end

    assign timed_out = r_timed_out;
`else
    wire w_run_tmo = 1'b0;
    wire [TMR_W-1:0] w_unused_run_limit = TMR_W'(MAX_RUN_CYCLES);
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mode      <= '0;
            r_bits_left <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_acc)
                r_mode <= mode;
            if (w_entering)
                r_bits_left <= BL_W'(CHAIN_LEN);
            else if (w_ld_shift || w_dm_shift)
                r_bits_left <= r_bits_left - 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (start) w_next_state = first_phase(mode);
            LOAD: if (w_ld_shift && (r_bits_left == BL_W'(1)))
                      w_next_state = first_phase({r_mode[MODE_DUMP], r_mode[MODE_RUN], 1'b0});
            RUN:  if (core_halt || w_run_tmo)
                      w_next_state = first_phase({r_mode[MODE_DUMP], 2'b00});
            DUMP: if (w_dm_take && w_bits_zero) w_next_state = DONE;
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // proc_en only exists in RUN and scan_enable only in LOAD/DUMP, so the
    // two can never be high together.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        core_scan_enable = 1'b0;
        core_scan_in     = 1'b0;
        core_proc_en     = 1'b0;
        case (r_state)
            LOAD: begin
                busy             = 1'b1;
                in_ready         = w_ld_empty && !w_bits_zero;
                core_scan_enable = w_ld_shift;
                core_scan_in     = w_ld_shift && w_ld_bit;
            end
            RUN: begin
                busy         = 1'b1;
                core_proc_en = 1'b1;
            end
            DUMP: begin
                busy             = 1'b1;
                out_valid        = w_dm_ready;
                core_scan_enable = w_dm_shift;
                core_scan_in     = w_dm_shift && core_scan_out;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign out_data = w_dm_data;

endmodule

// File: tb/tb_scan_chain_sequencer.sv
module tb_scan_chain_sequencer;

    localparam int CL   = 20;
    localparam int MAXR = 8;
    localparam int NB   = scan_seq_pkg::ceil_div(CL, 8);

    logic       clk, rst, start;
    logic [2:0] mode;
    logic       busy, done, timed_out;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic       core_scan_enable, core_scan_in, core_scan_out, core_proc_en, core_halt;

    scan_chain_sequencer #(.CHAIN_LEN(CL), .MAX_RUN_CYCLES(MAXR), .TMR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .timed_out(timed_out),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_scan_enable(core_scan_enable), .core_scan_in(core_scan_in),
        .core_scan_out(core_scan_out), .core_proc_en(core_proc_en),
        .core_halt(core_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: chain[0] is the scan_out end; halts halt_at cycles after proc_en rises.
    logic [CL-1:0] chain;
    int pe_total, se_total, busy_total, done_total, excl_viol, stall_viol;
    int halt_at, pe_base;
    int checks, errors;
    int pe_cnt, se_cnt, busy_cnt, done_cnt;
    logic [7:0] tx [NB];
    logic [7:0] rx [NB];
    logic [CL-1:0] snap;
    logic [15:0] all_out;

    assign core_scan_out = chain[0];
    assign core_halt = (halt_at >= 0) && ((pe_total - pe_base) >= halt_at);
    assign all_out = {busy, done, timed_out, in_ready, out_data, out_valid,
                      core_scan_enable, core_scan_in, core_proc_en};

    always @(posedge clk) begin
        if (core_scan_enable) chain <= {core_scan_in, chain[CL-1:1]};
        if (core_proc_en) pe_total <= pe_total + 1;
        if (core_scan_enable) se_total <= se_total + 1;
        if (busy) busy_total <= busy_total + 1;
        if (done) done_total <= done_total + 1;
        if (core_proc_en && core_scan_enable) excl_viol <= excl_viol + 1;
        if (out_valid && core_scan_enable) stall_viol <= stall_viol + 1;
    end

    function automatic logic [CL-1:0] chain_from(input logic [7:0] b [NB]);
        logic [CL-1:0] v;
        for (int i = 0; i < CL; i++) v[i] = b[i/8][i%8];
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input logic [CL-1:0] v, input int j);
        logic [7:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            idx = 8*j + k;
            if (idx < CL) r[k] = v[idx];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] m, input int stall, input int hlt);
        int b_pe, b_se, b_busy, b_done, n;
        logic [7:0] held;
        halt_at = hlt;
        pe_base = pe_total;
        b_pe = pe_total; b_se = se_total; b_busy = busy_total; b_done = done_total;
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0; mode = '0;
        if (m[0]) begin
            for (int j = 0; j < NB; j++) begin
                n = 0;
                while (!in_ready && n < 100) begin @(negedge clk); n++; end
                chk("in_ready_wait", in_ready, 1);
                in_data = tx[j]; in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0; in_data = '0;
            end
        end
        if (m[2]) begin
            for (int j = 0; j < NB; j++) begin
                n = 0;
                while (!out_valid && n < 300) begin @(negedge clk); n++; end
                chk("out_valid_wait", out_valid, 1);
                held = out_data;
                for (int s = 0; s < stall; s++) begin
                    start = s[0]; mode = 3'($urandom);
                    @(negedge clk);
                end
                start = 1'b0; mode = '0;
                chk("out_stable", out_data, held);
                rx[j] = out_data; out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("idle_after_done", busy, 0);
        pe_cnt = pe_total - b_pe; se_cnt = se_total - b_se;
        busy_cnt = busy_total - b_busy; done_cnt = done_total - b_done;
    endtask

    initial begin
        int n, b_se, b_busy, b_done, hl;
        logic [2:0] m;
        checks = 0; errors = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 chk("reset_outputs_x_in", all_out, 0);
        start = 0; mode = 0; in_data = 0; in_valid = 0; out_ready = 0; halt_at = -1; pe_base = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs_0_in", all_out, 0);
        rst = 1'b1;
        @(negedge clk);

        // mode 0: done next cycle, never busy
        b_busy = busy_total; b_done = done_total;
        start = 1'b1; mode = 3'b000;
        @(negedge clk);
        start = 1'b0;
        chk("m0_done", done, 1);
        chk("m0_busy", busy, 0);
        @(negedge clk);
        chk("m0_done_low", done, 0);
        chk("m0_busy_cycles", busy_total - b_busy, 0);
        chk("m0_done_cycles", done_total - b_done, 1);

        // load + dump of fixed pattern
        tx[0] = 8'hA5; tx[1] = 8'h3C; tx[2] = 8'h0F;
        run_cmd(3'b101, 0, -1);
        chk("ld_dump_b0", rx[0], 8'hA5);
        chk("ld_dump_b1", rx[1], 8'h3C);
        chk("ld_dump_b2", rx[2], 8'h0F);
        chk("ld_dump_chain_restored", chain, chain_from(tx));
        chk("ld_dump_shifts", se_cnt, 2*CL);
        chk("ld_dump_no_proc_en", pe_cnt, 0);

        // run only, halt 10 cycles after proc_en rises
        snap = chain;
        run_cmd(3'b010, 0, 10);
        chk("run_pe_cycles", pe_cnt, 11);
        chk("run_timed_out", timed_out, 0);
        chk("run_done_count", done_cnt, 1);
        chk("run_no_shift", se_cnt, 0);
        chk("run_chain_kept", chain, snap);

        // already halted on entry
        run_cmd(3'b010, 0, 0);
        chk("run_halted_entry", pe_cnt, 1);

        // randomized load/run/dump
        for (int it = 0; it < 5; it++) begin
            for (int j = 0; j < NB; j++) tx[j] = 8'($urandom);
            m = {1'b1, 1'($urandom), 1'b1};
            hl = int'($urandom_range(0, 12));
            run_cmd(m, int'($urandom_range(0, 3)), hl);
            for (int j = 0; j < NB; j++)
                chk("rand_dump_byte", rx[j], byte_of(chain_from(tx), j));
            chk("rand_chain", chain, chain_from(tx));
            chk("rand_pe_cycles", pe_cnt, m[1] ? hl + 1 : 0);
        end

        // dump only with 15-cycle host stall and ignored start pulses
        snap = chain;
        run_cmd(3'b100, 15, -1);
        for (int j = 0; j < NB; j++)
            chk("stall_dump_byte", rx[j], byte_of(snap, j));
        chk("stall_done_count", done_cnt, 1);
        chk("stall_shifts", se_cnt, CL);
        chk("stall_chain", chain, snap);

`ifdef RUN_TIMEOUT_EN
        snap = chain;
        run_cmd(3'b110, 2, -1);
        chk("tmo_pe_cycles", pe_cnt, MAXR);
        chk("tmo_flag", timed_out, 1);
        for (int j = 0; j < NB; j++)
            chk("tmo_dump_byte", rx[j], byte_of(snap, j));
        run_cmd(3'b000, 0, -1);
        chk("tmo_flag_cleared", timed_out, 0);
`endif

        // reset mid-load after 5 shifts
        for (int j = 0; j < NB; j++) tx[j] = 8'($urandom);
        halt_at = -1;
        start = 1'b1; mode = 3'b001;
        @(negedge clk);
        start = 1'b0; mode = '0;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        in_data = tx[0]; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        b_se = se_total; n = 0;
        while ((se_total - b_se) < 5 && n < 50) begin @(negedge clk); n++; end
        chk("mid_rst_shifts", se_total - b_se, 5);
        rst = 1'b0;
        #1 chk("mid_rst_outputs", all_out, 0);
        @(posedge clk); #1;
        chk("mid_rst_outputs_edge", all_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int j = 0; j < NB; j++) tx[j] = 8'($urandom);
        run_cmd(3'b101, 1, -1);
        for (int j = 0; j < NB; j++)
            chk("post_rst_dump_byte", rx[j], byte_of(chain_from(tx), j));
        chk("post_rst_chain", chain, chain_from(tx));

        chk("excl_violations", excl_viol, 0);
        chk("stall_violations", stall_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
